// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, write-back bypass of
// register-file read data, flush/stall bubble insertion and a saturating bubble counter.
module id_ex_stage #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic [ADDR_W-1:0] id_rd,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_alu_src,
  input  logic              id_reg_dst,
  input  logic [2:0]        id_alu_op,
  input  logic              wb_reg_write,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              stall,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_alu_src,
  output logic [2:0]        ex_alu_op,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [ADDR_W-1:0] ex_rs,
  output logic [ADDR_W-1:0] ex_rt,
  output logic [ADDR_W-1:0] ex_write_reg,
  output logic [7:0]        bubble_cnt
);

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned OP_W    = 3;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              ex_valid_q,     ex_valid_d;
  logic              ex_reg_write_q, ex_reg_write_d;
  logic              ex_mem_read_q,  ex_mem_read_d;
  logic              ex_mem_write_q, ex_mem_write_d;
  logic              ex_alu_src_q,   ex_alu_src_d;
  logic [OP_W-1:0]   ex_alu_op_q,    ex_alu_op_d;
  logic [DATA_W-1:0] ex_rs_data_q,   ex_rs_data_d;
  logic [DATA_W-1:0] ex_rt_data_q,   ex_rt_data_d;
  logic [DATA_W-1:0] ex_imm_q,       ex_imm_d;
  logic [ADDR_W-1:0] ex_rs_q,        ex_rs_d;
  logic [ADDR_W-1:0] ex_rt_q,        ex_rt_d;
  logic [ADDR_W-1:0] ex_write_reg_q, ex_write_reg_d;
  logic [CNT_W-1:0]  bubble_cnt_q,   bubble_cnt_d;

  logic load_use;
  logic stall_int;
  logic fwd_rs;
  logic fwd_rt;

  // Load in EX whose destination feeds the instruction in ID; register 0 never hazards.
  always_comb begin
    load_use  = id_valid && ex_valid_q && ex_mem_read_q &&
                (ex_write_reg_q != '0) &&
                ((ex_write_reg_q == id_rs) || (ex_write_reg_q == id_rt));
    stall_int = load_use && !flush;
    fwd_rs    = wb_reg_write && (wb_addr == id_rs) && (wb_addr != '0);
    fwd_rt    = wb_reg_write && (wb_addr == id_rt) && (wb_addr != '0);
  end

  assign stall = stall_int;

  // Next-state: bubble on flush/stall (datapath fields held), otherwise capture ID.
  always_comb begin
    ex_valid_d     = ex_valid_q;
    ex_reg_write_d = ex_reg_write_q;
    ex_mem_read_d  = ex_mem_read_q;
    ex_mem_write_d = ex_mem_write_q;
    ex_alu_src_d   = ex_alu_src_q;
    ex_alu_op_d    = ex_alu_op_q;
    ex_rs_data_d   = ex_rs_data_q;
    ex_rt_data_d   = ex_rt_data_q;
    ex_imm_d       = ex_imm_q;
    ex_rs_d        = ex_rs_q;
    ex_rt_d        = ex_rt_q;
    ex_write_reg_d = ex_write_reg_q;
    bubble_cnt_d   = bubble_cnt_q;

    if (flush || stall_int) begin
      ex_valid_d     = 1'b0;
      ex_reg_write_d = 1'b0;
      ex_mem_read_d  = 1'b0;
      ex_mem_write_d = 1'b0;
      if (id_valid && (bubble_cnt_q != CNT_MAX)) begin
        bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
      end
    end else begin
      ex_valid_d     = id_valid;
      ex_reg_write_d = id_valid && id_reg_write;
      ex_mem_read_d  = id_valid && id_mem_read;
      ex_mem_write_d = id_valid && id_mem_write;
      ex_alu_src_d   = id_valid && id_alu_src;
      ex_alu_op_d    = id_valid ? id_alu_op : '0;
      ex_rs_data_d   = fwd_rs ? wb_data : id_rs_data;
      ex_rt_data_d   = fwd_rt ? wb_data : id_rt_data;
      ex_imm_d       = id_imm;
      ex_rs_d        = id_rs;
      ex_rt_d        = id_rt;
      ex_write_reg_d = id_reg_dst ? id_rd : id_rt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q     <= 1'b0;
      ex_reg_write_q <= 1'b0;
      ex_mem_read_q  <= 1'b0;
      ex_mem_write_q <= 1'b0;
      ex_alu_src_q   <= 1'b0;
      ex_alu_op_q    <= '0;
      ex_rs_data_q   <= '0;
      ex_rt_data_q   <= '0;
      ex_imm_q       <= '0;
      ex_rs_q        <= '0;
      ex_rt_q        <= '0;
      ex_write_reg_q <= '0;
      bubble_cnt_q   <= '0;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_reg_write_q <= ex_reg_write_d;
      ex_mem_read_q  <= ex_mem_read_d;
      ex_mem_write_q <= ex_mem_write_d;
      ex_alu_src_q   <= ex_alu_src_d;
      ex_alu_op_q    <= ex_alu_op_d;
      ex_rs_data_q   <= ex_rs_data_d;
      ex_rt_data_q   <= ex_rt_data_d;
      ex_imm_q       <= ex_imm_d;
      ex_rs_q        <= ex_rs_d;
      ex_rt_q        <= ex_rt_d;
      ex_write_reg_q <= ex_write_reg_d;
      bubble_cnt_q   <= bubble_cnt_d;
    end
  end

  assign ex_valid     = ex_valid_q;
  assign ex_reg_write = ex_reg_write_q;
  assign ex_mem_read  = ex_mem_read_q;
  assign ex_mem_write = ex_mem_write_q;
  assign ex_alu_src   = ex_alu_src_q;
  assign ex_alu_op    = ex_alu_op_q;
  assign ex_rs_data   = ex_rs_data_q;
  assign ex_rt_data   = ex_rt_data_q;
  assign ex_imm       = ex_imm_q;
  assign ex_rs        = ex_rs_q;
  assign ex_rt        = ex_rt_q;
  assign ex_write_reg = ex_write_reg_q;
  assign bubble_cnt   = bubble_cnt_q;

endmodule
